// File: rtl/gbus_pkg.sv
// Shared widths, defaults and state encoding for the write-back collector.
package gbus_pkg;

  localparam int GBUS_MAC_MULT_NUM   = 16;
  localparam int GBUS_IDATA_WIDTH    = 8;
  localparam int GBUS_ADDR_WIDTH_DEF = 19;
  localparam int GBUS_FIFO_DEPTH     = 8;
  localparam int GBUS_CNT_WIDTH      = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } gbus_state_e;

endpackage

// File: rtl/gbus_wb_fifo.sv
// First-word-fall-through buffer between the core write-back port and the SRAM.
// A push into a full FIFO is still accepted when the head pops in the same cycle.
module gbus_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty.
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer registers; reset empties the buffer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gbus_wb_collector.sv
// Collects a configured number of core write-back beats and streams them to
// the global SRAM through a valid/ready port, tracking run status flags.
//
// state   | meaning
// IDLE    | no run armed since reset
// COLLECT | accepting beats until the expected count is reached
// DRAIN   | all beats received, emptying the buffer to SRAM
// DONE    | run complete and buffer empty; waits for the next cfg_vld
module gbus_wb_collector
  import gbus_pkg::*;
#(
  parameter int MAC_MULT_NUM    = GBUS_MAC_MULT_NUM,
  parameter int IDATA_WIDTH     = GBUS_IDATA_WIDTH,
  parameter int GBUS_DATA_WIDTH = MAC_MULT_NUM * IDATA_WIDTH,
  parameter int GBUS_ADDR_WIDTH = GBUS_ADDR_WIDTH_DEF,
  parameter int FIFO_DEPTH      = GBUS_FIFO_DEPTH,
  parameter int CNT_WIDTH       = GBUS_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [GBUS_ADDR_WIDTH-1:0] in_gbus_addr,
  input  logic                       in_gbus_wen,
  input  logic [GBUS_DATA_WIDTH-1:0] in_gbus_wdata,
  input  logic                       cfg_vld,
  input  logic [CNT_WIDTH-1:0]       cfg_exp_cnt,
  output logic                       sram_wen,
  output logic [GBUS_ADDR_WIDTH-1:0] sram_waddr,
  output logic [GBUS_DATA_WIDTH-1:0] sram_wdata,
  input  logic                       sram_wready,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       rx_cnt,
  output logic                       overflow,
  output logic                       stray,
  output logic                       cfg_err
);

  localparam int EW = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;

  gbus_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] exp_q, exp_d;
  logic [CNT_WIDTH-1:0] rx_q, rx_d;
  logic [CNT_WIDTH-1:0] rx_inc;
  logic                 ovf_q, ovf_d;
  logic                 stray_q, stray_d;
  logic                 cerr_q, cerr_d;

  logic                 fifo_push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [EW-1:0]        fifo_head;

  assign fifo_push = (state_q == ST_COLLECT) && in_gbus_wen;

  gbus_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({in_gbus_addr, in_gbus_wdata}),
    .pop   (sram_wready),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is gated so the SRAM port reads zero whenever nothing is offered.
  assign sram_wen   = !fifo_empty;
  assign sram_waddr = fifo_empty ? '0 : fifo_head[EW-1:GBUS_DATA_WIDTH];
  assign sram_wdata = fifo_empty ? '0 : fifo_head[GBUS_DATA_WIDTH-1:0];

  assign done     = (state_q == ST_DONE);
  assign rx_cnt   = rx_q;
  assign overflow = ovf_q;
  assign stray    = stray_q;
  assign cfg_err  = cerr_q;

  // Saturating beat counter so a stuck run never wraps back to zero.
  assign rx_inc = (rx_q == {CNT_WIDTH{1'b1}}) ? rx_q : rx_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Next-state, counters and sticky flags.
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    rx_d    = rx_q;
    ovf_d   = ovf_q;
    stray_d = stray_q;
    cerr_d  = cerr_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (cfg_vld) begin
          exp_d   = cfg_exp_cnt;
          rx_d    = '0;
          ovf_d   = 1'b0;
          stray_d = 1'b0;
          cerr_d  = 1'b0;
          state_d = (cfg_exp_cnt == '0) ? ST_DONE : ST_COLLECT;
        end
        // A beat alongside the arming pulse still lands as stray.
        if (in_gbus_wen) stray_d = 1'b1;
      end
      ST_COLLECT: begin
        if (cfg_vld) cerr_d = 1'b1;
        if (in_gbus_wen) begin
          rx_d = rx_inc;
          if (fifo_full && !sram_wready) ovf_d = 1'b1;
          if (rx_inc == exp_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_vld) cerr_d = 1'b1;
        if (in_gbus_wen) stray_d = 1'b1;
        if (fifo_empty) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      rx_q    <= '0;
      ovf_q   <= 1'b0;
      stray_q <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      rx_q    <= rx_d;
      ovf_q   <= ovf_d;
      stray_q <= stray_d;
      cerr_q  <= cerr_d;
    end
  end

endmodule

// File: tb/tb_gbus_wb_collector.sv
// Directed bench for gbus_wb_collector with a queue scoreboard on the SRAM port.
module tb_gbus_wb_collector;

  localparam int AW = 19;
  localparam int DW = 128;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic [AW-1:0] in_gbus_addr;
  logic          in_gbus_wen;
  logic [DW-1:0] in_gbus_wdata;
  logic          cfg_vld;
  logic [CW-1:0] cfg_exp_cnt;
  logic          sram_wen;
  logic [AW-1:0] sram_waddr;
  logic [DW-1:0] sram_wdata;
  logic          sram_wready;
  logic          done;
  logic [CW-1:0] rx_cnt;
  logic          overflow;
  logic          stray;
  logic          cfg_err;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int wr_base;

  logic [AW+DW-1:0] exp_q[$];

  gbus_wb_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_gbus_addr  (in_gbus_addr),
    .in_gbus_wen   (in_gbus_wen),
    .in_gbus_wdata (in_gbus_wdata),
    .cfg_vld       (cfg_vld),
    .cfg_exp_cnt   (cfg_exp_cnt),
    .sram_wen      (sram_wen),
    .sram_waddr    (sram_waddr),
    .sram_wdata    (sram_wdata),
    .sram_wready   (sram_wready),
    .done          (done),
    .rx_cnt        (rx_cnt),
    .overflow      (overflow),
    .stray         (stray),
    .cfg_err       (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // SRAM-side monitor: pops the scoreboard on each accepted write and checks
  // that a stalled write holds its address and data.
  logic          hold;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_data;
  initial hold = 1'b0;

  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        total++;
        assert (sram_wen === 1'b1 && sram_waddr === h_addr && sram_wdata === h_data)
        else begin
          bad++;
          $error("FAIL hold_stable: got wen=%0b addr=%0h want wen=1 addr=%0h", sram_wen, sram_waddr, h_addr);
        end
      end
      if (sram_wen === 1'b1 && sram_wready === 1'b1) begin
        wr_cnt++;
        total++;
        assert (exp_q.size() != 0)
        else begin
          bad++;
          $error("FAIL unexpected_write: got addr=%0h want no write", sram_waddr);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          total++;
          assert ({sram_waddr, sram_wdata} === e)
          else begin
            bad++;
            $error("FAIL write_order: got addr=%0h data=%0h want addr=%0h data=%0h",
                   sram_waddr, sram_wdata, e[AW+DW-1:DW], e[DW-1:0]);
          end
        end
      end
      hold   = (sram_wen === 1'b1) && (sram_wready === 1'b0);
      h_addr = sram_waddr;
      h_data = sram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int n);
    for (int i = 0; i < n && done !== 1'b1; i++) tick();
    check(tag, {63'd0, done}, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [7:0] b, input bit expect_it);
    in_gbus_wen   = 1'b1;
    in_gbus_addr  = a;
    in_gbus_wdata = {16{b}};
    if (expect_it) exp_q.push_back({a, {16{b}}});
  endtask

  initial begin
    rst = 1'b1;
    in_gbus_addr = '0;
    in_gbus_wen = 1'b0;
    in_gbus_wdata = '0;
    cfg_vld = 1'b0;
    cfg_exp_cnt = '0;
    sram_wready = 1'b0;
    tick();
    tick();

    // reset values
    check("rst_wen", {63'd0, sram_wen}, 64'd0);
    check("rst_waddr", {45'd0, sram_waddr}, 64'd0);
    check("rst_wdata", sram_wdata[63:0], 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_rx", {48'd0, rx_cnt}, 64'd0);
    check("rst_flags", {61'd0, overflow, stray, cfg_err}, 64'd0);
    rst = 1'b0;
    tick();

    // basic run: 4 back-to-back beats, ready always high
    sram_wready = 1'b1;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd4;
    tick();
    cfg_vld = 1'b0;
    wr_base = wr_cnt;
    for (int k = 0; k < 4; k++) begin
      beat(AW'(k), 8'h01, 1'b1);
      tick();
      check("t1_lat_wen", {63'd0, sram_wen}, 64'd1);
      check("t1_lat_addr", {45'd0, sram_waddr}, 64'(k));
    end
    in_gbus_wen = 1'b0;
    wait_done("t1_done", 10);
    check("t1_rx", {48'd0, rx_cnt}, 64'd4);
    check("t1_flags", {61'd0, overflow, stray, cfg_err}, 64'd0);
    check("t1_writes", 64'(wr_cnt - wr_base), 64'd4);

    // overflow: 10 beats into an 8-deep buffer with ready low
    sram_wready = 1'b0;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd10;
    tick();
    cfg_vld = 1'b0;
    wr_base = wr_cnt;
    for (int k = 0; k < 10; k++) begin
      beat(AW'(16 + k), 8'(8'h10 + k), k < 8);
      tick();
    end
    in_gbus_wen = 1'b0;
    check("t2_ovf", {63'd0, overflow}, 64'd1);
    check("t2_rx", {48'd0, rx_cnt}, 64'd10);
    check("t2_not_done", {63'd0, done}, 64'd0);
    check("t2_head", {45'd0, sram_waddr}, 64'd16);
    tick();
    sram_wready = 1'b1;
    wait_done("t2_done", 30);
    check("t2_writes", 64'(wr_cnt - wr_base), 64'd8);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // full buffer with a simultaneous pop still accepts the push
    sram_wready = 1'b0;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd9;
    tick();
    cfg_vld = 1'b0;
    wr_base = wr_cnt;
    for (int k = 0; k < 8; k++) begin
      beat(AW'(32 + k), 8'(8'h20 + k), 1'b1);
      tick();
    end
    sram_wready = 1'b1;
    beat(AW'(40), 8'h28, 1'b1);
    tick();
    in_gbus_wen = 1'b0;
    check("t2b_no_ovf", {63'd0, overflow}, 64'd0);
    wait_done("t2b_done", 30);
    check("t2b_writes", 64'(wr_cnt - wr_base), 64'd9);
    check("t2b_rx", {48'd0, rx_cnt}, 64'd9);

    // ready toggling 1010: stalled writes hold, done only after third write
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd3;
    tick();
    cfg_vld = 1'b0;
    wr_base = wr_cnt;
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      sram_wready = (i % 2 == 0);
      if (i < 3) beat(AW'(48 + i), 8'(8'h30 + i), 1'b1);
      else in_gbus_wen = 1'b0;
      tick();
      check("t3_done_early", {63'd0, (done === 1'b1) && (wr_cnt - wr_base < 3)}, 64'd0);
    end
    check("t3_done", {63'd0, done}, 64'd1);
    check("t3_writes", 64'(wr_cnt - wr_base), 64'd3);
    sram_wready = 1'b1;

    // stray beat with the arming pulse, then cfg_vld mid-run
    do_reset();
    wr_base = wr_cnt;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd2;
    beat(AW'(100), 8'hEE, 1'b0);
    tick();
    cfg_vld = 1'b0;
    check("t4_stray", {63'd0, stray}, 64'd1);
    check("t4_rx0", {48'd0, rx_cnt}, 64'd0);
    beat(AW'(101), 8'h41, 1'b1);
    tick();
    beat(AW'(102), 8'h42, 1'b1);
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd7;
    tick();
    cfg_vld = 1'b0;
    in_gbus_wen = 1'b0;
    check("t4_cfg_err", {63'd0, cfg_err}, 64'd1);
    wait_done("t4_done", 10);
    check("t4_rx", {48'd0, rx_cnt}, 64'd2);
    check("t4_flags", {61'd0, overflow, stray, cfg_err}, 64'd3);
    check("t4_writes", 64'(wr_cnt - wr_base), 64'd2);

    // zero-length run goes straight to done
    do_reset();
    wr_base = wr_cnt;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd0;
    tick();
    cfg_vld = 1'b0;
    check("t5_done", {63'd0, done}, 64'd1);
    check("t5_wen", {63'd0, sram_wen}, 64'd0);
    tick();
    tick();
    check("t5_writes", 64'(wr_cnt - wr_base), 64'd0);
    check("t5_done_hold", {63'd0, done}, 64'd1);

    // reset mid-drain with 5 beats buffered
    sram_wready = 1'b0;
    cfg_vld = 1'b1;
    cfg_exp_cnt = 16'd5;
    tick();
    cfg_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      beat(AW'(200 + k), 8'(8'h50 + k), 1'b1);
      tick();
    end
    in_gbus_wen = 1'b0;
    check("t6_pre_wen", {63'd0, sram_wen}, 64'd1);
    check("t6_pre_rx", {48'd0, rx_cnt}, 64'd5);
    rst = 1'b1;
    #1;
    check("t6_rst_wen", {63'd0, sram_wen}, 64'd0);
    check("t6_rst_waddr", {45'd0, sram_waddr}, 64'd0);
    check("t6_rst_rx", {48'd0, rx_cnt}, 64'd0);
    check("t6_rst_done", {63'd0, done}, 64'd0);
    exp_q.delete();
    wr_base = wr_cnt;
    tick();
    rst = 1'b0;
    sram_wready = 1'b1;
    repeat (10) tick();
    check("t6_no_writes", 64'(wr_cnt - wr_base), 64'd0);
    check("t6_idle_wen", {63'd0, sram_wen}, 64'd0);
    check("t6_idle_done", {63'd0, done}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
